// File: rtl/window_cnt_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : window_cnt_gen_if
// Description : Bundle of control inputs and status outputs of the
//               window_cnt_gen counter block.
//               master : drives EN/RESTART/ONESHOT/TERM/SET_PT/CLR_PT and
//                        observes CNT/WRAP/DONE/WIN
//               slave  : the counter block itself
// Revision    : 1.0 - initial release
// ============================================================================
interface window_cnt_gen_if #(
   parameter int WIDTH = 3,
   parameter int NCH   = 1
);
   logic                  EN;
   logic                  RESTART;
   logic                  ONESHOT;
   logic [WIDTH-1:0]      TERM;
   logic [NCH*WIDTH-1:0]  SET_PT;
   logic [NCH*WIDTH-1:0]  CLR_PT;
   logic [WIDTH-1:0]      CNT;
   logic                  WRAP;
   logic                  DONE;
   logic [NCH-1:0]        WIN;

   modport master (
      output EN, RESTART, ONESHOT, TERM, SET_PT, CLR_PT,
      input  CNT, WRAP, DONE, WIN
   );

   modport slave (
      input  EN, RESTART, ONESHOT, TERM, SET_PT, CLR_PT,
      output CNT, WRAP, DONE, WIN
   );
endinterface
`default_nettype wire

// File: rtl/window_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_cnt_gen
// Description : Programmable-terminal up-counter with per-channel set/clear
//               window flags, wrap strobe and one-shot completion flag.
// Ports       : CLK  - clock, rising edge
//               RST  - synchronous active-high reset
//               bus  - window_cnt_gen_if.slave
//                      EN      count enable
//                      RESTART synchronous restart (same as RST)
//                      ONESHOT 0 = free-run wrap, 1 = stop at terminal
//                      TERM    inclusive terminal count
//                      SET_PT  per-channel set points, WIDTH bits each
//                      CLR_PT  per-channel clear points, WIDTH bits each
//                      CNT     current count
//                      WRAP    one-cycle terminal strobe (registered)
//                      DONE    one-shot completion flag (registered)
//                      WIN     per-channel window flags (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module window_cnt_gen #(
   parameter int WIDTH = 3,
   parameter int NCH   = 1
) (
   input  wire              CLK,
   input  wire              RST,
   window_cnt_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap;
   logic             r_done;
   logic [NCH-1:0]   r_win;

   logic             w_clear;
   logic             w_at_term;
   logic [NCH-1:0]   w_set_hit;
   logic [NCH-1:0]   w_clr_hit;

   assign w_clear   = RST || bus.RESTART;
   // Compare with >= so a TERM lowered below the running count still
   // terminates on the next enabled cycle instead of overflowing.
   assign w_at_term = (r_cnt >= bus.TERM);

   // -------------------------------------------------------------------------
   // Counter, wrap strobe and one-shot flag
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (w_clear) begin
         r_cnt  <= c_zero;
         r_wrap <= 1'b0;
         r_done <= 1'b0;
      end else if (bus.EN && !r_done) begin
         if (w_at_term) begin
            r_wrap <= 1'b1;
            if (bus.ONESHOT) begin
               // Count is frozen; DONE blocks any further wrap pulses.
               r_done <= 1'b1;
            end else begin
               r_cnt  <= c_zero;
            end
         end else begin
            r_cnt  <= r_cnt + c_one;
            r_wrap <= 1'b0;
         end
      end else begin
         r_wrap <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Per-channel compare points
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_set_hit[gi] = (r_cnt == bus.SET_PT[gi*WIDTH +: WIDTH]);
      assign w_clr_hit[gi] = (r_cnt == bus.CLR_PT[gi*WIDTH +: WIDTH]);
   end

   // Windows track the count regardless of EN/DONE; clear beats set so a
   // channel with equal points never opens.
   always_ff @(posedge CLK) begin
      if (w_clear) begin
         r_win <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_clr_hit[i]) begin
               r_win[i] <= 1'b0;
            end else if (w_set_hit[i]) begin
               r_win[i] <= 1'b1;
            end
         end
      end
   end

   assign bus.CNT  = r_cnt;
   assign bus.WRAP = r_wrap;
   assign bus.DONE = r_done;
   assign bus.WIN  = r_win;

endmodule
`default_nettype wire

// File: tb/tb_window_cnt_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_cnt_gen
// Description : Directed self-checking bench for window_cnt_gen. Instance A
//               is WIDTH=3/NCH=1, instance B is WIDTH=4/NCH=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_cnt_gen;

   logic CLK = 1'b0;
   logic rst_a;
   logic rst_b;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   window_cnt_gen_if #(.WIDTH(3), .NCH(1)) bus_a ();
   window_cnt_gen_if #(.WIDTH(4), .NCH(2)) bus_b ();

   window_cnt_gen #(.WIDTH(3), .NCH(1)) u_dut_a (
      .CLK (CLK),
      .RST (rst_a),
      .bus (bus_a.slave)
   );

   window_cnt_gen #(.WIDTH(4), .NCH(2)) u_dut_b (
      .CLK (CLK),
      .RST (rst_b),
      .bus (bus_b.slave)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int cnt, input int wrap,
                        input int done, input int win);
      chk({tag, ".cnt"},  32'(bus_a.CNT),  cnt);
      chk({tag, ".wrap"}, 32'(bus_a.WRAP), wrap);
      chk({tag, ".done"}, 32'(bus_a.DONE), done);
      chk({tag, ".win"},  32'(bus_a.WIN),  win);
   endtask

   int fr_cnt  [14] = '{1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 5, 6, 0};
   int fr_wrap [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
   int fr_win  [14] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      bus_a.EN = 1'b0;  bus_a.RESTART = 1'b0; bus_a.ONESHOT = 1'b0;
      bus_a.TERM = 3'd6; bus_a.SET_PT = 3'd2; bus_a.CLR_PT = 3'd4;
      bus_b.EN = 1'b0;  bus_b.RESTART = 1'b0; bus_b.ONESHOT = 1'b0;
      bus_b.TERM = 4'd15;
      bus_b.SET_PT = {4'd12, 4'd3};
      bus_b.CLR_PT = {4'd1,  4'd3};

      step();
      step();
      chk_a("reset", 0, 0, 0, 0);

      // Free-run TERM=6, window SET=2 CLR=4
      rst_a = 1'b0;
      bus_a.EN = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         chk_a($sformatf("freerun[%0d]", k), fr_cnt[k], fr_wrap[k], 0, fr_win[k]);
      end

      // Advance to CNT=3, then hold with EN low for two cycles
      step(); chk_a("pre_hold1", 1, 0, 0, 0);
      step(); chk_a("pre_hold2", 2, 0, 0, 0);
      step(); chk_a("pre_hold3", 3, 0, 0, 1);
      bus_a.EN = 1'b0;
      step(); chk_a("hold1", 3, 0, 0, 1);
      step(); chk_a("hold2", 3, 0, 0, 1);
      bus_a.EN = 1'b1;
      step(); chk_a("resume1", 4, 0, 0, 1);
      step(); chk_a("resume2", 5, 0, 0, 0);

      // Lower TERM below the running count; CLR=4 is now unreachable
      bus_a.TERM = 3'd2;
      step(); chk_a("term_lo0", 0, 1, 0, 0);
      step(); chk_a("term_lo1", 1, 0, 0, 0);
      step(); chk_a("term_lo2", 2, 0, 0, 0);
      step(); chk_a("term_lo3", 0, 1, 0, 1);
      step(); chk_a("term_lo4", 1, 0, 0, 1);
      step(); chk_a("term_lo5", 2, 0, 0, 1);
      step(); chk_a("term_lo6", 0, 1, 0, 1);

      // Back to TERM=6, reach CNT=3 with WIN=1, then pulse RST
      bus_a.TERM = 3'd6;
      step(); chk_a("pre_rst1", 1, 0, 0, 1);
      step(); chk_a("pre_rst2", 2, 0, 0, 1);
      step(); chk_a("pre_rst3", 3, 0, 0, 1);
      rst_a = 1'b1;
      step(); chk_a("mid_rst", 0, 0, 0, 0);

      // One-shot TERM=5
      rst_a = 1'b0;
      bus_a.ONESHOT = 1'b1;
      bus_a.TERM = 3'd5;
      step(); chk_a("os1", 1, 0, 0, 0);
      step(); chk_a("os2", 2, 0, 0, 0);
      step(); chk_a("os3", 3, 0, 0, 1);
      step(); chk_a("os4", 4, 0, 0, 1);
      step(); chk_a("os5", 5, 0, 0, 0);
      step(); chk_a("os_done", 5, 1, 1, 0);
      step(); chk_a("os_stay", 5, 0, 1, 0);
      bus_a.ONESHOT = 1'b0;
      step(); chk_a("os_noreleas", 5, 0, 1, 0);
      bus_a.RESTART = 1'b1;
      step(); chk_a("restart", 0, 0, 0, 0);
      bus_a.RESTART = 1'b0;
      step(); chk_a("restart_run", 1, 0, 0, 0);

      // TERM=0 free-run: CNT pinned at 0, WRAP every enabled cycle
      bus_a.TERM = 3'd0;
      step(); chk_a("term0_a", 0, 1, 0, 0);
      step(); chk_a("term0_b", 0, 1, 0, 0);
      step(); chk_a("term0_c", 0, 1, 0, 0);

      // Instance B: two channels, equal points on ch0, wrap-spanning ch1
      step();
      chk("b_reset.cnt", 32'(bus_b.CNT), 0);
      chk("b_reset.win", 32'(bus_b.WIN), 0);
      rst_b = 1'b0;
      bus_b.EN = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         int c;
         int w1;
         step();
         c  = k % 16;
         w1 = (k >= 13 && (c >= 13 || c <= 1)) ? 1 : 0;
         chk($sformatf("b[%0d].cnt", k),  32'(bus_b.CNT),    c);
         chk($sformatf("b[%0d].wrap", k), 32'(bus_b.WRAP),   (k == 16) ? 1 : 0);
         chk($sformatf("b[%0d].win0", k), 32'(bus_b.WIN[0]), 0);
         chk($sformatf("b[%0d].win1", k), 32'(bus_b.WIN[1]), w1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/window_cnt_gen.md
# window_cnt_gen

Parametrised, programmable-terminal up-counter with per-channel set/clear window flags. It is the general successor of the fixed 3-bit wrap counter and single window flag used in the timing logic. It adds configurable width, runtime terminal count, multiple window channels, enable/restart control and a one-shot mode. It sits beside the control FSMs and supplies periodic phase windows and a wrap strobe.

## Interface
- WIDTH, 3: counter and compare-point width (1..16).
- NCH, 1: number of window channels (1..8).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; counter holds when low.
- RESTART  in  1  synchronous restart: counter, windows and DONE cleared (same effect as RST).
- ONESHOT  in  1  mode: 0 = free-run wrap, 1 = stop at terminal.
- TERM  in  WIDTH  terminal count (inclusive); period = TERM+1 enabled cycles.
- SET_PT  in  NCH*WIDTH  per-channel set point; channel i uses bits [i*WIDTH +: WIDTH].
- CLR_PT  in  NCH*WIDTH  per-channel clear point, same packing.
- CNT  out  WIDTH  current count.
- WRAP  out  1  one-cycle pulse, registered.
- DONE  out  1  one-shot completion flag, registered.
- WIN  out  NCH  per-channel window flags, registered.

## Operation
- Reset/RESTART (RST has priority, RESTART is equivalent): CNT=0, WRAP=0, DONE=0, WIN=0.
- Counter, with EN=1 and DONE=0:
  - CNT >= TERM, ONESHOT=0: CNT <- 0, WRAP <- 1.
  - CNT >= TERM, ONESHOT=1: CNT holds, DONE <- 1, WRAP <- 1 (once only).
  - Otherwise: CNT <- CNT+1, WRAP <- 0.
- EN=0: CNT holds, WRAP <- 0.
- DONE=1: CNT frozen at its value and WRAP stays 0 until RST or RESTART. Deasserting ONESHOT does not release it.
- Terminal compare is >=. If TERM is lowered below the current CNT mid-run, the next enabled cycle takes the terminal action. No overflow past TERM is possible.
- TERM=0: free-run CNT stays 0 and WRAP pulses on every enabled cycle.
- Window channel i is evaluated every cycle, independent of EN and DONE:
  - CNT == CLR_PT[i]: WIN[i] <- 0.
  - else CNT == SET_PT[i]: WIN[i] <- 1.
  - else WIN[i] holds.
- SET_PT == CLR_PT: clear wins, so WIN stays 0.
- A point above TERM is never matched, so that edge never fires.
- Compare-point or TERM changes take effect on the next compare. There is no shadowing.

## Timing
- CNT changes on the rising edge following an enabled cycle.
- WRAP is high in the cycle where CNT first shows 0 after a wrap. In one-shot mode it is high in the cycle DONE first reads 1.
- WIN[i] lags its matching CNT value by one cycle: it rises in the cycle after CNT == SET_PT[i] and falls in the cycle after CNT == CLR_PT[i].
- With EN held high, free-run period is exactly TERM+1 cycles and WRAP spacing is TERM+1.
- RST or RESTART asserted mid-count: all outputs are 0 in the following cycle. Counting resumes from 0 on the first enabled cycle after release.
- Single-cycle latency throughout; no combinational input-to-output paths.

## Test plan
- WIDTH=3, TERM=6, NCH=1, SET=2, CLR=4, EN=1, free-run:
  - CNT runs 0..6 then 0.
  - WRAP is high every 7th cycle, aligned with CNT=0.
  - WIN=1 while CNT in {3,4}; it rises after CNT=2 and falls after CNT=4.
- ONESHOT=1, TERM=5: CNT stops at 5 and DONE=1 from the next cycle, with a single WRAP pulse. RESTART -> all outputs 0 and counting restarts.
- EN toggled 1,0,0,1 at CNT=3: CNT holds at 3 for two cycles. WIN does not change during the hold, and WRAP stays low.
- TERM changed 6->2 while CNT=5: next enabled cycle gives CNT=0 and WRAP=1. Subsequent period is 3 cycles.
- NCH=2, WIDTH=4, TERM=15:
  - ch0 SET=3, CLR=3: WIN[0] stays 0.
  - ch1 SET=12, CLR=1: WIN[1] spans the wrap, rising after 12 and falling after 1.
- RST pulsed mid-window at CNT=3, WIN=1: next cycle CNT=0, WIN=0, WRAP=0, DONE=0.
